spi_controller: RTL and testbench

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_clk_div.sv | 30 +++
 rtl/spi_controller.sv | 166 ++++++++++++++++
 tb/tb_spi_controller.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI write-only register controller.
// Frame layout is {write bit, 7-bit address, 8-bit data}, MSB first.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } spi_state_e;

  localparam int FRAME_W = 16;
  localparam int DIV_W   = 8;
  localparam int BIT_W   = 5;

  localparam logic WRITE_BIT = 1'b1;

  // Register map of the attached peripheral
  localparam logic [6:0] EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] PWM_DUTY    = 7'h04;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [6:0] addr,
                                                     input logic [7:0] data);
    return {WRITE_BIT, addr, data};
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: down-counter that fires every CLK_DIV clk cycles
// and reloads whenever the controller enters a new state.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || (cnt_q == '0)) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write controller: latches {1, addr, data} and shifts it out MSB first.
// Optional one-entry command queue enabled by defining SPI_CTRL_QUEUE_EN.
//
// state | meaning
// IDLE  | ncs high, waiting for a command
// SETUP | ncs low, first bit on copi, sclk low for CLK_DIV cycles
// SHIFT | 16 bit periods, sclk high then low, CLK_DIV cycles each phase
// GAP   | ncs high for CLK_DIV cycles before the next frame
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       sclk,
  output logic       ncs,
  output logic       copi,
  output logic       busy,
  output logic       done
);

  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_W);
  localparam logic [BIT_W-1:0] LAST_SHIFT = BIT_W'(FRAME_W - 1);

  spi_state_e         state_q, state_d;
  logic [FRAME_W-1:0] frame_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic               sclk_hi_q;
  logic               done_q;
  logic               rdy_en_q;
  logic               tick;
  logic               restart;
  logic               accept;
  logic               start_cmd;

`ifdef SPI_CTRL_QUEUE_EN
  logic               pend_valid_q;
  logic [FRAME_W-1:0] pend_frame_q;
  logic               start_pend;

  assign cmd_ready = rdy_en_q & ~pend_valid_q;
`else
  assign cmd_ready = rdy_en_q & (state_q == ST_IDLE);
`endif

  assign accept = cmd_valid & cmd_ready;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    start_cmd = 1'b0;
`ifdef SPI_CTRL_QUEUE_EN
    start_pend = 1'b0;
`endif
    ncs  = 1'b1;
    sclk = 1'b0;
    copi = 1'b0;
    busy = (state_q != ST_IDLE);
    done = done_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SETUP;
          start_cmd = 1'b1;
        end
      end
      ST_SETUP: begin
        ncs  = 1'b0;
        copi = frame_q[FRAME_W-1];
        if (tick) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        ncs  = 1'b0;
        sclk = sclk_hi_q;
        copi = frame_q[FRAME_W-1];
        if (tick && !sclk_hi_q && (bit_cnt_q == LAST_BIT)) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (tick) begin
`ifdef SPI_CTRL_QUEUE_EN
          // A command arriving in the last GAP cycle starts directly instead of
          // detouring through the pending register.
          if (pend_valid_q) begin
            state_d    = ST_SETUP;
            start_pend = 1'b1;
          end else if (accept) begin
            state_d   = ST_SETUP;
            start_cmd = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    restart = (state_d != state_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      sclk_hi_q <= 1'b0;
      done_q    <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      done_q   <= (state_q == ST_SHIFT) && (state_d == ST_GAP);

      if (start_cmd) begin
        frame_q <= build_frame(cmd_addr, cmd_data);
`ifdef SPI_CTRL_QUEUE_EN
      end else if (start_pend) begin
        frame_q <= pend_frame_q;
`endif
      end else if ((state_q == ST_SHIFT) && tick && sclk_hi_q && (bit_cnt_q < LAST_SHIFT)) begin
        // Advance on the falling edge; bit 0 stays put through the last low phase.
        frame_q <= {frame_q[FRAME_W-2:0], 1'b0};
      end

      if (state_d != ST_SHIFT) begin
        sclk_hi_q <= 1'b0;
        bit_cnt_q <= '0;
      end else if (state_q != ST_SHIFT) begin
        sclk_hi_q <= 1'b1;
        bit_cnt_q <= '0;
      end else if (tick) begin
        sclk_hi_q <= ~sclk_hi_q;
        if (sclk_hi_q) bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end
  end

`ifdef SPI_CTRL_QUEUE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_frame_q <= '0;
    end else if (start_pend) begin
      pend_valid_q <= 1'b0;
    end else if (accept && !start_cmd) begin
      pend_valid_q <= 1'b1;
      pend_frame_q <= build_frame(cmd_addr, cmd_data);
    end
  end
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: two instances (CLK_DIV=4 and CLK_DIV=1), a bus
// monitor acting as the register peripheral, table-driven and random frames.
module tb_spi_controller;
  import spi_pkg::*;

  localparam int DIV0 = 4;
  localparam int DIV1 = 1;
`ifdef SPI_CTRL_QUEUE_EN
  localparam int GAP_EXP = DIV0;
`else
  localparam int GAP_EXP = DIV0 + 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid [2];
  logic [6:0] cmd_addr  [2];
  logic [7:0] cmd_data  [2];
  logic       cmd_ready [2];
  logic       sclk      [2];
  logic       ncs       [2];
  logic       copi      [2];
  logic       busy      [2];
  logic       done      [2];

  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(DIV0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_addr(cmd_addr[0]), .cmd_data(cmd_data[0]), .sclk(sclk[0]), .ncs(ncs[0]),
    .copi(copi[0]), .busy(busy[0]), .done(done[0]));

  spi_controller #(.CLK_DIV(DIV1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_addr(cmd_addr[1]), .cmd_data(cmd_data[1]), .sclk(sclk[1]), .ncs(ncs[1]),
    .copi(copi[1]), .busy(busy[1]), .done(done[1]));

  int checks   = 0;
  int failures = 0;

  // Peripheral-side view of each bus, updated once per clk cycle on the falling edge.
  int          frames[2], rise_cnt[2], low_cnt[2], hi_cnt[2], done_cnt[2], prot_err[2];
  int          last_rise[2], last_low[2], last_gap[2];
  logic [15:0] rx[2], last_rx[2];
  logic        ncs_p[2]  = '{1'b1, 1'b1};
  logic        sclk_p[2] = '{1'b0, 1'b0};
  logic        copi_p[2] = '{1'b0, 1'b0};
  logic        done_p[2] = '{1'b0, 1'b0};
  logic [7:0]  preg[0:127];

  task automatic monitor_step();
    for (int g = 0; g < 2; g++) begin
      if (!ncs[g] && ncs_p[g]) begin
        last_gap[g] = hi_cnt[g];
        hi_cnt[g] = 0; low_cnt[g] = 0; rise_cnt[g] = 0; rx[g] = '0;
      end
      if (ncs[g]) hi_cnt[g]++; else low_cnt[g]++;
      if (sclk[g] && !sclk_p[g] && !ncs[g]) begin
        rx[g] = {rx[g][14:0], copi[g]};
        rise_cnt[g]++;
      end
      if (ncs[g] && !ncs_p[g]) begin
        last_rx[g] = rx[g]; last_rise[g] = rise_cnt[g]; last_low[g] = low_cnt[g];
        frames[g]++;
        if (g == 0 && rise_cnt[g] == 16 && rx[g][15]) preg[rx[g][14:8]] = rx[g][7:0];
      end
      if (done[g]) done_cnt[g]++;
      if (done[g] && done_p[g]) prot_err[g]++;
      if (sclk[g] && ncs[g]) prot_err[g]++;
      if (!ncs[g] && !busy[g]) prot_err[g]++;
      if (!ncs[g] && !ncs_p[g] && (copi[g] != copi_p[g]) && !(sclk_p[g] && !sclk[g])) prot_err[g]++;
`ifndef SPI_CTRL_QUEUE_EN
      if (cmd_ready[g] && busy[g]) prot_err[g]++;
`endif
      ncs_p[g] = ncs[g]; sclk_p[g] = sclk[g]; copi_p[g] = copi[g]; done_p[g] = done[g];
    end
  endtask

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int div_of(input int g);
    return (g == 0) ? DIV0 : DIV1;
  endfunction

  // Presents a command and returns once the accepting edge has passed; inputs are
  // then scrambled to show the frame does not depend on them after acceptance.
  task automatic send(input int g, input logic [6:0] a, input logic [7:0] d, output bit ok);
    ok = 1'b0;
    cmd_valid[g] = 1'b1; cmd_addr[g] = a; cmd_data[g] = d;
    for (int n = 0; n < 1000; n++) begin
      if (cmd_ready[g]) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    cmd_valid[g] = 1'b0;
    cmd_addr[g]  = 7'($urandom);
    cmd_data[g]  = 8'($urandom);
  endtask

  task automatic wait_frames(input int g, input int target, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (frames[g] >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_frame(input int g, input logic [6:0] a, input logic [7:0] d,
                          input logic [15:0] exp, input string nm);
    int f0, dn0;
    bit ok;
    f0 = frames[g]; dn0 = done_cnt[g];
    send(g, a, d, ok);
    chk({nm, "_accepted"}, 32'(ok), 32'd1);
    wait_frames(g, f0 + 1, ok);
    chk({nm, "_frame_seen"}, 32'(ok), 32'd1);
    repeat (3) tick();
    chk({nm, "_bits"}, 32'(last_rx[g]), 32'(exp));
    chk({nm, "_sclk_rises"}, 32'(last_rise[g]), 32'd16);
    chk({nm, "_ncs_low"}, 32'(last_low[g]), 32'(33 * div_of(g)));
    chk({nm, "_done_pulses"}, 32'(done_cnt[g] - dn0), 32'd1);
  endtask

  typedef struct {
    int          inst;
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] exp_frame;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int  f0, dn0, acc;
    bit  ok;
    logic [6:0] ra;
    logic [7:0] rd;

    tbl[0] = '{0, EN_OUT_7_0,  8'h11, 16'h8011};
    tbl[1] = '{0, EN_OUT_15_8, 8'h22, 16'h8122};
    tbl[2] = '{0, EN_PWM_7_0,  8'h33, 16'h8233};
    tbl[3] = '{0, EN_PWM_15_8, 8'h44, 16'h8344};
    tbl[4] = '{0, PWM_DUTY,    8'hA5, 16'h84A5};
    tbl[5] = '{1, 7'h00,       8'hFF, 16'h80FF};
    tbl[6] = '{1, 7'h7F,       8'h00, 16'hFF00};
    tbl[7] = '{0, 7'h55,       8'h5A, 16'hD55A};

    for (int g = 0; g < 2; g++) begin
      cmd_valid[g] = 1'b0; cmd_addr[g] = '0; cmd_data[g] = '0;
    end
    for (int i = 0; i < 128; i++) preg[i] = 8'h00;

    // Reset values
    rst_n = 1'b0;
    #2;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_ncs%0d", g),   32'(ncs[g]),       32'd1);
      chk($sformatf("rst_sclk%0d", g),  32'(sclk[g]),      32'd0);
      chk($sformatf("rst_copi%0d", g),  32'(copi[g]),      32'd0);
      chk($sformatf("rst_done%0d", g),  32'(done[g]),      32'd0);
      chk($sformatf("rst_busy%0d", g),  32'(busy[g]),      32'd0);
      chk($sformatf("rst_ready%0d", g), 32'(cmd_ready[g]), 32'd0);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    chk("ready_before_edge", 32'(cmd_ready[0]), 32'd0);
    tick();
    chk("ready_first_edge0", 32'(cmd_ready[0]), 32'd1);
    chk("ready_first_edge1", 32'(cmd_ready[1]), 32'd1);

    // Table-driven frames
    for (int i = 0; i < 8; i++)
      do_frame(tbl[i].inst, tbl[i].addr, tbl[i].data, tbl[i].exp_frame, $sformatf("tbl%0d", i));

    // Loopback: the peripheral registers hold what was written
    for (int i = 0; i < 5; i++)
      chk($sformatf("loopback_reg%0d", i), 32'(preg[tbl[i].addr]), 32'(tbl[i].data));

    // Command held valid across a transfer, second command issued right behind it
    f0 = frames[0]; dn0 = done_cnt[0]; acc = 0;
    cmd_valid[0] = 1'b1; cmd_addr[0] = EN_OUT_15_8; cmd_data[0] = 8'h0F;
    for (int n = 0; n < 2000 && acc < 2; n++) begin
      if (cmd_ready[0]) begin
        acc++;
        tick();
        if (acc == 1) begin
          cmd_addr[0] = EN_PWM_7_0; cmd_data[0] = 8'hF0;
        end else begin
          cmd_valid[0] = 1'b0;
        end
      end else begin
        tick();
      end
    end
    cmd_valid[0] = 1'b0;
    chk("held_accepts", 32'(acc), 32'd2);
    wait_frames(0, f0 + 1, ok);
    chk("held_frame1_bits", 32'(last_rx[0]), 32'h810F);
    wait_frames(0, f0 + 2, ok);
    chk("held_frame2_seen", 32'(ok), 32'd1);
    chk("held_frame2_bits", 32'(last_rx[0]), 32'h82F0);
    chk("held_ncs_gap", 32'(last_gap[0]), 32'(GAP_EXP));
    chk("held_frame2_low", 32'(last_low[0]), 32'(33 * DIV0));
    repeat (200) tick();
    chk("held_frame_count", 32'(frames[0] - f0), 32'd2);
    chk("held_done_pulses", 32'(done_cnt[0] - dn0), 32'd2);

    // Reset mid-frame after 7 sclk rises
    f0 = frames[0]; dn0 = done_cnt[0];
    send(0, PWM_DUTY, 8'hA5, ok);
    chk("midrst_accepted", 32'(ok), 32'd1);
    for (int n = 0; n < 1000 && rise_cnt[0] < 7; n++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_ncs", 32'(ncs[0]), 32'd1);
    chk("midrst_sclk", 32'(sclk[0]), 32'd0);
    chk("midrst_ready", 32'(cmd_ready[0]), 32'd0);
    repeat (2) tick();
    chk("midrst_frame_end", 32'(frames[0] - f0), 32'd1);
    chk("midrst_rises", 32'(last_rise[0]), 32'd7);
    chk("midrst_no_done", 32'(done_cnt[0] - dn0), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("midrst_ready_after", 32'(cmd_ready[0]), 32'd1);
    chk("midrst_reg_untouched", 32'(preg[PWM_DUTY]), 32'hA5);
    do_frame(0, EN_OUT_7_0, 8'hC3, 16'h80C3, "after_rst");

    // Random frames against the frame-format model
    for (int i = 0; i < 10; i++) begin
      ra = 7'($urandom_range(127));
      rd = 8'($urandom_range(255));
      do_frame(i % 2, ra, rd, {1'b1, ra, rd}, $sformatf("rnd%0d", i));
    end

    chk("protocol0", 32'(prot_err[0]), 32'd0);
    chk("protocol1", 32'(prot_err[1]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
